// File: rtl/instruction_decode_pkg.sv
// Shared constants for the instruction decode register file and its hazard scoreboard.
package instruction_decode_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int ZERO_REG_IDX       = 0;
    localparam int NUM_REGS           = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one busy bit per register, flush/clear/set priority,
// and a busy lookup for every read port.
module reg_scoreboard
    import instruction_decode_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           clr_valid,
    input  logic [ADDR_WIDTH-1:0]          clr_idx,
    input  logic                           set_valid,
    input  logic [ADDR_WIDTH-1:0]          set_idx,
    input  logic                           flush,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ-1:0]            busy_r
);

    localparam int DEPTH = num_regs(ADDR_WIDTH);

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic             set_allowed;

    assign set_allowed = set_valid &&
                         !((ZERO_REG != 0) && (set_idx == ADDR_WIDTH'(ZERO_REG_IDX)));

    // Set is applied last so a newly issued producer outlives both the flush
    // and a writeback retiring the previous producer of the same register.
    always_comb begin
        busy_next = flush ? '0 : busy_reg;
        if (clr_valid) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_allowed) begin
            busy_next[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_lookup
            assign busy_r[gi] = busy_reg[ra[gi*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    endgenerate

endmodule

// File: rtl/register_bank_mp.sv
// Multi-read-port register file for decode: posedge write, optional write-to-read
// bypass, optional hardwired zero register and per-port RAW hazard flags.
module register_bank_mp
    import instruction_decode_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] bus_r,
    output logic [NUM_READ-1:0]            busy_r,
    input  logic                           reg_write,
    input  logic [ADDR_WIDTH-1:0]          rw,
    input  logic [DATA_WIDTH-1:0]          busw,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    input  logic                           flush
);

    localparam int DEPTH = num_regs(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic                  write_allowed;
    logic [NUM_READ-1:0]   sb_busy;

    assign write_allowed = reg_write &&
                           !((ZERO_REG != 0) && (rw == ADDR_WIDTH'(ZERO_REG_IDX)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (write_allowed) begin
            regs_reg[rw] <= busw;
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_valid  (reg_write),
        .clr_idx    (rw),
        .set_valid  (issue_valid),
        .set_idx    (issue_rd),
        .flush      (flush),
        .ra         (ra),
        .busy_r     (sb_busy)
    );

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
            logic [ADDR_WIDTH-1:0] addr;
            logic                  bypass_hit;
            logic                  zero_hit;
            logic [DATA_WIDTH-1:0] rd_data;

            assign addr       = ra[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign bypass_hit = (BYPASS != 0) && reg_write && (rw == addr);
            assign zero_hit   = (ZERO_REG != 0) && (addr == ADDR_WIDTH'(ZERO_REG_IDX));

            // Zero register beats bypass; outputs are held at 0 while in reset
            // even if the writeback bus is still active.
            always_comb begin
                rd_data = regs_reg[addr];
                if (bypass_hit) begin
                    rd_data = busw;
                end
                if (zero_hit || !reset_n) begin
                    rd_data = '0;
                end
            end

            assign bus_r[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data;
            assign busy_r[gi] = reset_n && sb_busy[gi] && !bypass_hit;
        end
    endgenerate

endmodule
